// File: rtl/audio_pack_fifo.sv
// ============================================================================
// audio_pack_fifo: packs DIN_W-bit lanes into RATIO-lane words and buffers
// them in a block-RAM FIFO with a show-ahead output register.
// Rev 1.0
// ============================================================================
`default_nettype none

module audio_pack_fifo #(
  parameter int DIN_W      = 8,
  parameter int RATIO      = 4,
  parameter int DEPTH      = 128,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       s_valid,
  input  logic [DIN_W-1:0]           s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic                       m_valid,
  output logic [DIN_W*RATIO-1:0]     m_data,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(RATIO):0]     lanes
);

  localparam int WW  = DIN_W * RATIO;
  localparam int AW  = $clog2(DEPTH);
  localparam int LVW = AW + 1;
  localparam int LNW = $clog2(RATIO) + 1;
  localparam logic [LNW-1:0] LAST_LANE = LNW'(RATIO - 1);
  localparam logic [LVW-1:0] FULL_LVL  = LVW'(DEPTH);

  logic [WW-1:0]  acc;
  logic [WW-1:0]  acc_next;
  logic [LNW-1:0] lane_idx;
  logic           accept;
  logic           commit;
  logic           pop;
  logic           out_load;
  logic           rd_issue;

  logic [WW-1:0]  mem [DEPTH];
  logic [WW-1:0]  rd_data;
  logic           rd_valid;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LVW-1:0] ram_cnt;

  // level counts RAM, read stage and output register, so it alone bounds intake
  assign s_ready  = (level < FULL_LVL) && !flush;
  assign accept   = s_valid && s_ready;
  assign commit   = accept && ((lanes == LAST_LANE) || s_last);
  assign pop      = m_valid && m_ready && !flush;
  assign out_load = rd_valid && (!m_valid || m_ready);
  assign rd_issue = (ram_cnt != '0) && (!rd_valid || out_load);

  always_comb begin
    lane_idx = (BIG_ENDIAN != 0) ? (LAST_LANE - lanes) : lanes;
    acc_next = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_idx == LNW'(k)) acc_next[k*DIN_W +: DIN_W] = s_data;
    end
  end

  // Storage kept free of reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (commit)   mem[wr_ptr] <= acc_next;
    if (rd_issue) rd_data     <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc      <= '0;
      lanes    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else if (flush) begin
      acc      <= '0;
      lanes    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      if (accept) begin
        if (commit) begin
          acc    <= '0;
          lanes  <= '0;
          wr_ptr <= wr_ptr + AW'(1);
        end else begin
          acc    <= acc_next;
          lanes  <= lanes + LNW'(1);
        end
      end

      if (rd_issue) rd_ptr <= rd_ptr + AW'(1);

      unique case ({commit, rd_issue})
        2'b10:   ram_cnt <= ram_cnt + LVW'(1);
        2'b01:   ram_cnt <= ram_cnt - LVW'(1);
        default: ram_cnt <= ram_cnt;
      endcase

      unique case ({commit, pop})
        2'b10:   level <= level + LVW'(1);
        2'b01:   level <= level - LVW'(1);
        default: level <= level;
      endcase

      if (rd_issue)      rd_valid <= 1'b1;
      else if (out_load) rd_valid <= 1'b0;

      if (out_load) begin
        m_valid <= 1'b1;
        m_data  <= rd_data;
      end else if (pop) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
